// File: rtl/uart_apb_sequencer.sv
// APB master that programs a CoreUARTapb and then shuttles bytes by polling its status register.
// Optional `UART_SEQ_RR_ARB_EN: round-robin RX/TX arbitration (default: RX has fixed priority).
module uart_apb_sequencer #(
   parameter int         POLL_GAP   = 4,
   parameter logic [4:0] ADDR_TX    = 5'h00,
   parameter logic [4:0] ADDR_RX    = 5'h04,
   parameter logic [4:0] ADDR_CTRL1 = 5'h08,
   parameter logic [4:0] ADDR_CTRL2 = 5'h0C,
   parameter logic [4:0] ADDR_STAT  = 5'h10
) (
   input  logic        PCLK,
   input  logic        PRESETN,
   input  logic [12:0] cfg_baud,
   input  logic        cfg_bit8,
   input  logic        cfg_parity_en,
   input  logic        cfg_odd_n_even,
   input  logic        cfg_start,
   output logic        cfg_done,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [4:0]  PADDR,
   output logic [7:0]  PWDATA,
   input  logic [7:0]  PRDATA,
   input  logic        PREADY,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic [2:0]  err_flags,
   input  logic        err_clr,
   output logic        busy
);
   localparam int GW = (POLL_GAP > 2) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   typedef enum logic [2:0] {IDLE, WR_CTRL1, WR_CTRL2, POLL, GAP, RD_RX, WR_TX} state_t;

   state_t        state, nxt;
   logic          launch;
   logic [12:0]   baud_q;
   logic          bit8_q, par_q, odd_q, cfg_pend;
   logic [GW-1:0] gap_cnt;
   logic          xfer_done, cfg_acc, cfg_req, rx_pend, tx_pend, pick_rx;
   logic [7:0]    ctrl1_data;
   logic [4:0]    nxt_addr;
   logic          nxt_wr;
   logic [7:0]    nxt_data;
   logic          unused_prdata;

   assign busy          = PSEL;
   assign xfer_done     = PENABLE && PREADY;
   assign cfg_acc       = cfg_start && (state != WR_CTRL1) && (state != WR_CTRL2);
   assign cfg_req       = cfg_acc || cfg_pend;
   assign ctrl1_data    = cfg_acc ? cfg_baud[7:0] : baud_q[7:0];
   // A full holding register masks RXRDY, which is the consumer backpressure.
   assign rx_pend       = PRDATA[1] && !rx_valid;
   assign tx_pend       = PRDATA[0] && tx_valid;
   assign unused_prdata = ^PRDATA[7:5];

`ifdef UART_SEQ_RR_ARB_EN
   logic last_tx;
   assign pick_rx = rx_pend && (!tx_pend || last_tx);
`else
   assign pick_rx = rx_pend;
`endif

   always_comb begin
      nxt    = state;
      launch = 1'b0;
      case (state)
         IDLE:     if (cfg_acc) begin nxt = WR_CTRL1; launch = 1'b1; end
         WR_CTRL1: if (xfer_done) begin nxt = WR_CTRL2; launch = 1'b1; end
         WR_CTRL2: if (xfer_done) begin nxt = POLL; launch = 1'b1; end
         POLL: if (xfer_done) begin
            launch = 1'b1;
            if (cfg_req)            nxt = WR_CTRL1;
            else if (pick_rx)       nxt = RD_RX;
            else if (tx_pend)       nxt = WR_TX;
            else if (POLL_GAP == 0) nxt = POLL;
            else begin              nxt = GAP; launch = 1'b0; end
         end
         GAP: begin
            if (cfg_req)                    begin nxt = WR_CTRL1; launch = 1'b1; end
            else if (gap_cnt == GAP_LAST)   begin nxt = POLL; launch = 1'b1; end
         end
         RD_RX, WR_TX: if (xfer_done) begin
            launch = 1'b1;
            nxt    = cfg_req ? WR_CTRL1 : POLL;
         end
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      nxt_addr = ADDR_STAT;
      nxt_wr   = 1'b0;
      nxt_data = 8'h00;
      case (nxt)
         WR_CTRL1: begin nxt_addr = ADDR_CTRL1; nxt_wr = 1'b1; nxt_data = ctrl1_data; end
         WR_CTRL2: begin nxt_addr = ADDR_CTRL2; nxt_wr = 1'b1;
                         nxt_data = {baud_q[12:8], odd_q, par_q, bit8_q}; end
         RD_RX:    nxt_addr = ADDR_RX;
         WR_TX:    begin nxt_addr = ADDR_TX; nxt_wr = 1'b1; nxt_data = tx_data; end
         default:  nxt_addr = ADDR_STAT;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state     <= IDLE;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         cfg_done  <= 1'b0;
         tx_ready  <= 1'b0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         err_flags <= '0;
         baud_q    <= '0;
         bit8_q    <= 1'b0;
         par_q     <= 1'b0;
         odd_q     <= 1'b0;
         cfg_pend  <= 1'b0;
         gap_cnt   <= '0;
`ifdef UART_SEQ_RR_ARB_EN
         last_tx   <= 1'b1;
`endif
      end else begin
         state    <= nxt;
         tx_ready <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         // A fresh error reported in the same cycle as err_clr survives the clear.
         err_flags <= (err_clr ? 3'b000 : err_flags) |
                      ((state == POLL && xfer_done) ? PRDATA[4:2] : 3'b000);
         if (cfg_acc) begin
            baud_q   <= cfg_baud;
            bit8_q   <= cfg_bit8;
            par_q    <= cfg_parity_en;
            odd_q    <= cfg_odd_n_even;
            cfg_pend <= 1'b1;
         end
         gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
         if (PSEL && !PENABLE) PENABLE <= 1'b1;
         if (xfer_done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
         end
         if (state == WR_CTRL2 && xfer_done) cfg_done <= 1'b1;
         if (state == RD_RX && xfer_done) begin
            rx_data  <= PRDATA;
            rx_valid <= 1'b1;
         end
         if (launch) begin
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            PWRITE  <= nxt_wr;
            PADDR   <= nxt_addr;
            PWDATA  <= nxt_data;
            if (nxt == WR_CTRL1) begin
               cfg_done <= 1'b0;
               cfg_pend <= 1'b0;
            end
            if (nxt == WR_TX) tx_ready <= 1'b1;
`ifdef UART_SEQ_RR_ARB_EN
            if (nxt == RD_RX) last_tx <= 1'b0;
            if (nxt == WR_TX) last_tx <= 1'b1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: a small APB slave model plus a log of completed transfers.
module tb_uart_apb_sequencer;
   localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h04, A_C1 = 5'h08, A_C2 = 5'h0C, A_ST = 5'h10;

   typedef struct packed {
      logic [4:0] addr;
      logic       wr;
      logic [7:0] data;
   } xfer_t;

   logic        PCLK, PRESETN;
   logic [12:0] cfg_baud;
   logic        cfg_bit8, cfg_parity_en, cfg_odd_n_even, cfg_start, cfg_done;
   logic        PSEL, PENABLE, PWRITE, PREADY;
   logic [4:0]  PADDR;
   logic [7:0]  PWDATA, PRDATA;
   logic [7:0]  tx_data, rx_data;
   logic        tx_valid, tx_ready, rx_valid, rx_ready, err_clr, busy;
   logic [2:0]  err_flags;
   logic [7:0]  stat_val, rx_val;

   int    n_tests, n_fail;
   xfer_t log_q[$];

   uart_apb_sequencer dut (
      .PCLK(PCLK), .PRESETN(PRESETN),
      .cfg_baud(cfg_baud), .cfg_bit8(cfg_bit8), .cfg_parity_en(cfg_parity_en),
      .cfg_odd_n_even(cfg_odd_n_even), .cfg_start(cfg_start), .cfg_done(cfg_done),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .err_flags(err_flags), .err_clr(err_clr), .busy(busy)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   assign PRDATA = (PADDR == A_ST) ? stat_val : rx_val;

   always @(posedge PCLK)
      if (PRESETN && PSEL && PENABLE && PREADY)
         log_q.push_back('{PADDR, PWRITE, PWRITE ? PWDATA : PRDATA});

   task automatic test_reset();
      @(negedge PCLK); @(negedge PCLK);
      n_tests++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, cfg_done, tx_ready, rx_data, rx_valid,
           err_flags, busy} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h done=%b rxv=%b err=%b",
                  PSEL, PENABLE, PADDR, PWDATA, cfg_done, rx_valid, err_flags);
      end
      PRESETN = 1'b1;
   endtask

   task automatic test_config();
      logic early;
      early = 1'bx;
      @(negedge PCLK);
      log_q.delete();
      cfg_baud = 13'h0A5; cfg_bit8 = 1'b1; cfg_parity_en = 1'b1; cfg_odd_n_even = 1'b0;
      cfg_start = 1'b1;
      @(negedge PCLK);
      cfg_start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (log_q.size() == 1) early = cfg_done;
      end
      n_tests++;
      if (log_q.size() < 3) begin
         n_fail++; $display("FAIL cfg_xfers: got %0d transfers want >=3", log_q.size());
      end else begin
         n_tests += 2;
         if (log_q[0] !== xfer_t'({A_C1, 1'b1, 8'hA5})) begin
            n_fail++; $display("FAIL cfg_ctrl1: got %h want %h", log_q[0], xfer_t'({A_C1, 1'b1, 8'hA5}));
         end
         if (log_q[1] !== xfer_t'({A_C2, 1'b1, 8'h03})) begin
            n_fail++; $display("FAIL cfg_ctrl2: got %h want %h", log_q[1], xfer_t'({A_C2, 1'b1, 8'h03}));
         end
         if (log_q[2].addr !== A_ST || log_q[2].wr !== 1'b0) begin
            n_fail++; $display("FAIL cfg_first_poll: got addr %h wr %b want addr 10 wr 0",
                               log_q[2].addr, log_q[2].wr);
         end
      end
      n_tests += 2;
      if (early !== 1'b0) begin
         n_fail++; $display("FAIL cfg_done_early: got %b want 0", early);
      end
      if (cfg_done !== 1'b1) begin
         n_fail++; $display("FAIL cfg_done: got %b want 1", cfg_done);
      end
   endtask

   task automatic test_tx();
      int pulses, wr_idx, wr_cnt;
      pulses = 0; wr_idx = -1; wr_cnt = 0;
      @(negedge PCLK);
      log_q.delete();
      stat_val = 8'h01; tx_data = 8'h5A; tx_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge PCLK);
         if (tx_ready) begin
            pulses++;
            tx_valid = 1'b0; stat_val = 8'h00;
         end
      end
      tx_valid = 1'b0; stat_val = 8'h00;
      foreach (log_q[i]) if (log_q[i].wr) begin wr_cnt++; if (wr_idx < 0) wr_idx = i; end
      n_tests += 3;
      if (pulses !== 1) begin
         n_fail++; $display("FAIL tx_ready_pulses: got %0d want 1", pulses);
      end
      if (wr_cnt !== 1) begin
         n_fail++; $display("FAIL tx_write_count: got %0d want 1", wr_cnt);
      end
      if (wr_idx < 1 || wr_idx + 1 >= log_q.size()) begin
         n_fail++; $display("FAIL tx_write_position: got index %0d of %0d", wr_idx, log_q.size());
      end else begin
         n_tests += 2;
         if (log_q[wr_idx] !== xfer_t'({A_TX, 1'b1, 8'h5A})) begin
            n_fail++; $display("FAIL tx_write: got %h want %h", log_q[wr_idx], xfer_t'({A_TX, 1'b1, 8'h5A}));
         end
         if (log_q[wr_idx-1].addr !== A_ST || log_q[wr_idx+1].addr !== A_ST) begin
            n_fail++; $display("FAIL tx_polls_around: got before %h after %h want 10 10",
                               log_q[wr_idx-1].addr, log_q[wr_idx+1].addr);
         end
      end
   endtask

   task automatic test_arb();
      logic [2:0] order, want;
      int n_svc;
      order = '0; n_svc = 0;
`ifdef UART_SEQ_RR_ARB_EN
      want = 3'b101;
`else
      want = 3'b111;
`endif
      @(negedge PCLK);
      log_q.delete();
      rx_ready = 1'b1; rx_val = 8'h11; tx_data = 8'h77; tx_valid = 1'b1; stat_val = 8'h03;
      for (int i = 0; i < 100 && n_svc < 3; i++) begin
         @(negedge PCLK);
         n_svc = 0;
         foreach (log_q[j])
            if ((log_q[j].addr == A_TX && log_q[j].wr) || (log_q[j].addr == A_RX && !log_q[j].wr)) begin
               if (n_svc < 3) order[2-n_svc] = (log_q[j].addr == A_RX);
               n_svc++;
            end
      end
      stat_val = 8'h00; tx_valid = 1'b0;
      n_tests++;
      if (n_svc < 3 || order !== want) begin
         n_fail++; $display("FAIL arb_order: got %b (%0d services) want %b (1=RX)", order, n_svc, want);
      end
      repeat (10) @(negedge PCLK);
   endtask

   task automatic test_rx();
      int rd_cnt, poll_cnt;
      @(negedge PCLK);
      rx_ready = 1'b0; log_q.delete();
      rx_val = 8'hC3; stat_val = 8'h02;
      repeat (40) @(negedge PCLK);
      rd_cnt = 0; poll_cnt = 0;
      foreach (log_q[i]) begin
         if (log_q[i].addr == A_RX) rd_cnt++;
         if (log_q[i].addr == A_ST) poll_cnt++;
      end
      n_tests += 4;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid: got %b want 1", rx_valid); end
      if (rx_data !== 8'hC3) begin n_fail++; $display("FAIL rx_data: got %h want c3", rx_data); end
      if (rd_cnt !== 1) begin n_fail++; $display("FAIL rx_backpressure_reads: got %0d want 1", rd_cnt); end
      if (poll_cnt < 3) begin n_fail++; $display("FAIL rx_polls: got %0d want >=3", poll_cnt); end
      rx_ready = 1'b1;
      @(negedge PCLK);
      rx_ready = 1'b0; rx_val = 8'h3C; log_q.delete();
      n_tests++;
      if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rx_valid_clear: got %b want 0", rx_valid); end
      repeat (30) @(negedge PCLK);
      n_tests += 2;
      if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rx_valid2: got %b want 1", rx_valid); end
      if (rx_data !== 8'h3C) begin n_fail++; $display("FAIL rx_data2: got %h want 3c", rx_data); end
      stat_val = 8'h00; rx_ready = 1'b1;
      repeat (3) @(negedge PCLK);
      rx_ready = 1'b0;
   endtask

   task automatic test_err();
      bit seen;
      @(negedge PCLK);
      log_q.delete(); stat_val = 8'h1C;
      for (int i = 0; i < 40 && log_q.size() == 0; i++) @(negedge PCLK);
      stat_val = 8'h00;
      n_tests++;
      if (err_flags !== 3'b111) begin n_fail++; $display("FAIL err_all: got %b want 111", err_flags); end
      err_clr = 1'b1;
      @(negedge PCLK);
      err_clr = 1'b0;
      n_tests++;
      if (err_flags !== 3'b000) begin n_fail++; $display("FAIL err_clear: got %b want 000", err_flags); end
      log_q.delete(); stat_val = 8'h14;
      for (int i = 0; i < 40 && log_q.size() == 0; i++) @(negedge PCLK);
      stat_val = 8'h00;
      n_tests++;
      if (err_flags !== 3'b101) begin n_fail++; $display("FAIL err_fram_par: got %b want 101", err_flags); end
      err_clr = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge PCLK);
         if (PSEL && PENABLE && PADDR == A_ST) begin seen = 1'b1; stat_val = 8'h08; end
      end
      @(negedge PCLK);
      err_clr = 1'b0; stat_val = 8'h00;
      n_tests++;
      if (!seen || err_flags !== 3'b010) begin
         n_fail++; $display("FAIL err_clr_race: got %b want 010 (poll seen %b)", err_flags, seen);
      end
      err_clr = 1'b1;
      @(negedge PCLK);
      err_clr = 1'b0;
   endtask

   task automatic test_wait_reset();
      bit found, stable;
      int act;
      found = 1'b0; stable = 1'b1; act = 0;
      @(negedge PCLK);
      stat_val = 8'h01; tx_data = 8'h96; tx_valid = 1'b1;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge PCLK);
         if (tx_ready) tx_valid = 1'b0;
         if (PSEL && !PENABLE && PWRITE && PADDR == A_TX) begin
            found = 1'b1; PREADY = 1'b0; stat_val = 8'h00;
         end
      end
      tx_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         if (!(PSEL && PENABLE && PWRITE && PADDR == A_TX && PWDATA == 8'h96)) stable = 1'b0;
      end
      n_tests++;
      if (!found || !stable) begin
         n_fail++; $display("FAIL wait_stable: got found=%b stable=%b paddr=%h pwdata=%h want 1 1 00 96",
                            found, stable, PADDR, PWDATA);
      end
      #2 PRESETN = 1'b0;
      #1;
      n_tests++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, cfg_done, tx_ready, rx_data, rx_valid,
           err_flags, busy} !== 31'd0) begin
         n_fail++; $display("FAIL async_reset: psel=%b pen=%b paddr=%h pwdata=%h done=%b busy=%b want all 0",
                            PSEL, PENABLE, PADDR, PWDATA, cfg_done, busy);
      end
      @(negedge PCLK);
      PREADY = 1'b1; stat_val = 8'h01; tx_valid = 1'b1;
      PRESETN = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (PSEL || cfg_done) act++;
      end
      tx_valid = 1'b0;
      n_tests++;
      if (act !== 0) begin n_fail++; $display("FAIL idle_after_reset: got %0d active cycles want 0", act); end
   endtask

   initial begin
      n_tests = 0; n_fail = 0;
      PRESETN = 1'b0; PREADY = 1'b1; stat_val = 8'h00; rx_val = 8'h00;
      cfg_baud = '0; cfg_bit8 = 1'b0; cfg_parity_en = 1'b0; cfg_odd_n_even = 1'b0; cfg_start = 1'b0;
      tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0; err_clr = 1'b0;
      test_reset();
      test_config();
      test_tx();
      test_arb();
      test_rx();
      test_err();
      test_wait_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
